// File: rtl/soc_system_ocr_pkg.sv
`default_nettype none
// ============================================================================
// soc_system_ocr_pkg
// Shared defaults and helpers for the two-port on-chip RAM arbiter.
// Revision: 1.0
// ============================================================================
package soc_system_ocr_pkg;

  localparam int unsigned c_ADDR_W       = 10;
  localparam int unsigned c_DATA_W       = 32;
  localparam int unsigned c_BE_W         = 4;
  localparam int unsigned c_PORT_ID_W    = 1;
  localparam int unsigned c_READ_LATENCY = 2;

  typedef logic [c_PORT_ID_W-1:0] port_id_t;

  // One-hot two-port grant to port index; an idle grant maps to port 0.
  function automatic port_id_t grant_to_id(input logic [1:0] grant);
    return port_id_t'(grant[1]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/soc_system_ocr_rr_arb.sv
`default_nettype none
// ============================================================================
// soc_system_ocr_rr_arb
// Two-requester round-robin arbiter with a last-grant pointer register.
// Revision: 1.0
// ============================================================================
module soc_system_ocr_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // Index of the port granted most recently; 1 lets port 0 win first contention.
  logic r_last;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (|grant) begin
      r_last <= grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/soc_system_ocr_arbiter.sv
`default_nettype none
// ============================================================================
// soc_system_ocr_arbiter
// Round-robin two-port front end to a single-port RAM, 2-cycle read latency.
// Revision: 1.0
// ============================================================================
module soc_system_ocr_arbiter
  import soc_system_ocr_pkg::*;
#(
  parameter int unsigned ADDR_W = c_ADDR_W,
  parameter int unsigned DATA_W = c_DATA_W,
  parameter int unsigned BE_W   = c_BE_W
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] s0_address,
  input  logic [BE_W-1:0]   s0_byteenable,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writedata,
  output logic              s0_waitrequest,
  output logic [DATA_W-1:0] s0_readdata,
  output logic              s0_readdatavalid,

  input  logic [ADDR_W-1:0] s1_address,
  input  logic [BE_W-1:0]   s1_byteenable,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic              s1_waitrequest,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,

  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_accept;
  port_id_t          w_sel_id;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [BE_W-1:0]   w_sel_be;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_write;

  logic              r_s1_valid;
  logic              r_s1_write;
  port_id_t          r_s1_port;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [BE_W-1:0]   r_s1_be;
  logic [DATA_W-1:0] r_s1_wdata;

  logic              r_s2_valid;
  port_id_t          r_s2_port;

  assign w_req = {s1_read | s1_write, s0_read | s0_write};

  soc_system_ocr_rr_arb u_rr_arb (
    .clk   (clk),
    .rst   (reset),
    .req   (w_req),
    .grant (w_grant)
  );

  assign s0_waitrequest = w_req[0] & ~w_grant[0];
  assign s1_waitrequest = w_req[1] & ~w_grant[1];
  assign w_accept       = |w_grant;
  assign w_sel_id       = grant_to_id(w_grant);

  // A write wins over a simultaneous read on the same port.
  always_comb begin
    w_sel_addr  = s0_address;
    w_sel_be    = s0_byteenable;
    w_sel_wdata = s0_writedata;
    w_sel_write = s0_write;
    if (w_grant[1]) begin
      w_sel_addr  = s1_address;
      w_sel_be    = s1_byteenable;
      w_sel_wdata = s1_writedata;
      w_sel_write = s1_write;
    end
  end

  // Stage 1: command register feeding the RAM; payload holds while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_write <= 1'b0;
      r_s1_port  <= '0;
      r_s1_addr  <= '0;
      r_s1_be    <= '0;
      r_s1_wdata <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_write <= w_sel_write;
        r_s1_port  <= w_sel_id;
        r_s1_addr  <= w_sel_addr;
        r_s1_be    <= w_sel_be;
        r_s1_wdata <= w_sel_wdata;
      end
    end
  end

  // Stage 2: read tag aligned with the RAM's registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_port  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid & ~r_s1_write;
      r_s2_port  <= r_s1_port;
    end
  end

  assign ram_address    = r_s1_addr;
  assign ram_byteenable = r_s1_be;
  assign ram_writedata  = r_s1_wdata;
  assign ram_chipselect = r_s1_valid;
  assign ram_write      = r_s1_valid & r_s1_write;

  assign s0_readdata      = ram_readdata;
  assign s1_readdata      = ram_readdata;
  assign s0_readdatavalid = r_s2_valid & (r_s2_port == port_id_t'(0));
  assign s1_readdatavalid = r_s2_valid & (r_s2_port == port_id_t'(1));

endmodule
`default_nettype wire

// File: doc/soc_system_ocr_arbiter.md
SOC_SYSTEM_OCR_ARBITER -- requirements
Module: soc_system_ocr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM word-address width (1024 words).
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter BE_W, default 4, byteenable width (DATA_W/8).
REQ-004 SHALL have one clock and an asynchronous, active-high reset:
  clk  in  1  clock
  reset  in  1  asynchronous active-high reset
REQ-005 SHALL provide two requester ports, N = 0 and 1, each with:
  sN_address  in  ADDR_W  word address
  sN_byteenable  in  BE_W  write byte lanes
  sN_read  in  1  read request
  sN_write  in  1  write request
  sN_writedata  in  DATA_W  write data
  sN_waitrequest  out  1  request not accepted this cycle
  sN_readdata  out  DATA_W  read data
  sN_readdatavalid  out  1  sN_readdata valid
REQ-006 SHALL provide the RAM-side port:
  ram_address  out  ADDR_W
  ram_byteenable  out  BE_W
  ram_chipselect  out  1
  ram_write  out  1
  ram_writedata  out  DATA_W
  ram_readdata  in  DATA_W  (valid one cycle after the RAM samples its address)

Function
REQ-007 SHALL treat port N as requesting when sN_read|sN_write; if both are high, the write SHALL be performed and no read data returned.
REQ-008 SHALL grant at most one port per cycle; sN_waitrequest = requestN & ~grantN, combinational; an accepted request is one with sN_waitrequest low while requesting.
REQ-009 SHALL arbitrate round-robin: sole requester wins; if both request, the port not granted last wins; the last-grant pointer updates only on a grant.
REQ-010 SHALL register the accepted command (address, byteenable, writedata, write flag, port id, valid) into stage 1, which drives the ram_* outputs in cycle A+1 for acceptance cycle A.
REQ-011 ram_chipselect SHALL equal stage-1 valid; ram_write SHALL equal stage-1 valid & write flag; ram_* data and address SHALL hold their last value when not valid.
REQ-012 SHALL carry a read tag (valid, port id) into stage 2; sN_readdatavalid SHALL be high in cycle A+2 only for the accepted read's port, with sN_readdata = ram_readdata.
REQ-013 Fixed read latency SHALL be 2 cycles; throughput SHALL be one access per cycle with back-to-back grants.
REQ-014 Writes SHALL produce no readdatavalid; byteenable 0 SHALL pass through unchanged.
REQ-015 Responses SHALL be returned in acceptance order; a read following a write to the same address SHALL return the new data.
REQ-016 sN_readdata SHALL be driven from ram_readdata regardless of valid; consumers qualify it with readdatavalid.

Reset
REQ-017 During reset: stage-1 and stage-2 valid = 0, ram_chipselect = 0, ram_write = 0, ram_address/byteenable/writedata = 0, readdatavalid = 0, last-grant pointer = 1 (port 0 wins first contention).
REQ-018 Reset asserted mid-operation SHALL discard in-flight commands and reads; no readdatavalid SHALL follow reset release for pre-reset requests.
REQ-019 sN_waitrequest SHALL remain combinational from requests during reset, and no grant SHALL be registered while reset is high.

Structure
REQ-020 Package soc_system_ocr_pkg SHALL hold ADDR_W/DATA_W/BE_W defaults, port-id width (1), and the read-latency constant (2).
REQ-021 Round-robin logic SHALL be a sub-module soc_system_ocr_rr_arb (req[1:0] -> grant[1:0], pointer register inside).

Verification
REQ-022 s0 write 0x12345678 to addr 0x005, be 0xF; then s0 read 0x005 -> s0_readdatavalid at A+2, data 0x12345678; s1_readdatavalid stays low.
REQ-023 s0 and s1 both read continuously for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; each port sees 3 readdatavalid pulses with correct data.
REQ-024 s1 write 0xAABBCCDD to 0x3FF, be 0x3 over initial 0x00000000 -> s1 read of 0x3FF returns 0x0000CCDD (wrap/top address).
REQ-025 s0 read+write together to 0x010 with 0xCAFEF00D -> RAM written, no s0_readdatavalid; subsequent read returns 0xCAFEF00D.
REQ-026 Assert reset one cycle after s1 read acceptance -> no s1_readdatavalid after release; ram_chipselect 0 during reset; first contention after release is won by s0.
